multicycle_controller: RTL

Moore-style control FSM for the multicycle MIPS core; sits directly upstream of `datapath` and drives every one of its control inputs. It consumes the opcode field `OP` that `datapath` decodes from its instruction register. It sequences fetch, decode, execute, memory and writeback states for `lw`, `sw`, R-type, `beq`, `addi` and `j`. ALU function decoding from `Funct` stays inside `datapath`; this block only issues `ALUOp`.

---
 rtl/multicycle_controller.sv | 125 ++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS core: sequences fetch/decode/execute/
// memory/writeback and drives every datapath control from the current state.
module multicycle_controller (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] OP,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       Branch,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [1:0] ALUOp,
  output logic       InstrDone,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t state_q, state_d;
  state_t out_s;
  logic   op_legal;

  always_comb begin
    op_legal = (OP == OP_LW) || (OP == OP_SW) || (OP == OP_RTYP) ||
               (OP == OP_BEQ) || (OP == OP_ADDI) || (OP == OP_J);
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (OP)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYP:      state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: state_d = (OP == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  state_d = MEMWB;
      EXEC:   state_d = ALUWB;
      ADDIEX: state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // During reset the outputs present FETCH values, with all write enables masked.
  always_comb begin
    out_s     = reset ? FETCH : state_q;
    IorD      = 1'b0;
    ALUSrcA   = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    Branch    = 1'b0;
    ALUSrcB   = 2'b00;
    PCSrc     = 2'b00;
    ALUOp     = 2'b00;
    InstrDone = 1'b0;
    case (out_s)
      FETCH:  begin ALUSrcB = 2'b01; IRWrite = 1'b1; PCWrite = 1'b1; end
      DECODE: begin ALUSrcB = 2'b11; InstrDone = ~op_legal; end
      MEMADR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
      MEMRD:  IorD = 1'b1;
      MEMWB:  begin MemtoReg = 1'b1; RegWrite = 1'b1; InstrDone = 1'b1; end
      MEMWR:  begin IorD = 1'b1; MemWrite = 1'b1; InstrDone = 1'b1; end
      EXEC:   begin ALUSrcA = 1'b1; ALUOp = 2'b10; end
      ALUWB:  begin RegDst = 1'b1; RegWrite = 1'b1; InstrDone = 1'b1; end
      BRANCH: begin
        ALUSrcA = 1'b1; ALUOp = 2'b01; PCSrc = 2'b01; Branch = 1'b1; InstrDone = 1'b1;
      end
      ADDIEX: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
      ADDIWB: begin RegWrite = 1'b1; InstrDone = 1'b1; end
      JUMP:   begin PCSrc = 2'b10; PCWrite = 1'b1; InstrDone = 1'b1; end
      default: ;
    endcase
    if (reset) begin
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      Branch    = 1'b0;
      InstrDone = 1'b0;
    end
    State = out_s;
  end

endmodule
